// File: rtl/keyboard_spi_tx.sv
// SPI mode-0 master: key codes queued through a valid/ready port, one MSB-first frame per byte.
// Latency: a byte popped in IDLE drops cs_n on the next cycle; cs_n stays low 17*HALF cycles.
// Backpressure: in_ready = !full from the registered FIFO count, forced low while rst is high.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   in_data/valid/rdy key code input handshake (byte taken on in_valid & in_ready)
//   sck, mosi, cs_n   SPI bus; sck idles low, cs_n rising edge commits the byte
//   busy              frame in progress or FIFO non-empty
//   tx_done           one-cycle pulse on the cycle cs_n returns high
module keyboard_spi_tx #(
    parameter int HALF  = 4,
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sck,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       tx_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP * HALF - 1);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [2:0]    state;

    assign in_ready = !rst && (count != DEPTH_C);
    assign push     = in_valid && in_ready;
    // The FSM only takes a byte from the registered count, so a byte pushed
    // this cycle is never bypassed straight onto the bus.
    assign pop      = (state == S_IDLE) && (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    logic [15:0] cnt;       // half-period / gap cycle counter
    logic [7:0]  shreg;     // byte being sent
    logic [2:0]  bit_idx;   // bit currently on mosi
    logic        last_bit;  // set once bit 0 has been clocked: next LOW ends the frame
    logic        half_end;

    assign half_end = (cnt == HALF_LAST);
    assign busy     = (state != S_IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            bit_idx  <= 3'd7;
            last_bit <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg    <= mem[rd_ptr];
                        mosi     <= mem[rd_ptr][7];
                        cs_n     <= 1'b0;
                        sck      <= 1'b0;
                        bit_idx  <= 3'd7;
                        last_bit <= 1'b0;
                        cnt      <= '0;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (half_end) begin
                        cnt   <= '0;
                        sck   <= 1'b1;
                        state <= S_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (half_end) begin
                        cnt   <= '0;
                        sck   <= 1'b0;
                        state <= S_LOW;
                        // mosi changes on the falling edge so it has a full
                        // half-period of setup before the next rising edge.
                        if (bit_idx != 3'd0) begin
                            bit_idx <= bit_idx - 3'd1;
                            mosi    <= shreg[bit_idx - 3'd1];
                        end else begin
                            last_bit <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (!last_bit) begin
                            sck   <= 1'b1;
                            state <= S_HIGH;
                        end else begin
                            cs_n    <= 1'b1;
                            mosi    <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= S_GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyboard_spi_tx.sv
// Bench for keyboard_spi_tx: two instances (HALF=4/GAP=2 and HALF=1/GAP=1) against a frame-level model.
// Latency: model predicts outputs from the cycle offset inside each frame.
// Backpressure: byte pushes wait on in_ready with a bounded retry loop.
module tb_keyboard_spi_tx;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] vin;
    logic [7:0] din [2];
    logic [1:0] rdy, sck, mosi, csn, busy, txd;

    keyboard_spi_tx #(.HALF(4), .DEPTH(DEPTH), .GAP(2)) dut0 (
        .clk(clk), .rst(rst[0]), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
        .sck(sck[0]), .mosi(mosi[0]), .cs_n(csn[0]), .busy(busy[0]), .tx_done(txd[0])
    );

    keyboard_spi_tx #(.HALF(1), .DEPTH(DEPTH), .GAP(1)) dut1 (
        .clk(clk), .rst(rst[1]), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
        .sck(sck[1]), .mosi(mosi[1]), .cs_n(csn[1]), .busy(busy[1]), .tx_done(txd[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int hp(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int gp(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // ------------------------------------------------------------------
    // Frame-level model: mo = cycles since cs_n fell (-1 outside a frame),
    // mgap = cs_n-high cycles still owed before the next byte may start.
    // ------------------------------------------------------------------
    int         mo [2]   = '{-1, -1};
    int         mgap [2] = '{0, 0};
    logic [7:0] mcur [2];
    logic [7:0] mbuf [2][256];
    int         mh [2] = '{0, 0};
    int         mt [2] = '{0, 0};
    logic [7:0] sbuf [2][256];
    int         sh [2] = '{0, 0};
    int         st [2] = '{0, 0};
    logic [1:0] etx    = 2'b00;
    logic [1:0] active = 2'b00;
    logic       m_push, m_pop;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            etx[i] = 1'b0;
            if (rst[i]) begin
                active[i] = 1'b1;
                mh[i] = 0; mt[i] = 0; sh[i] = 0; st[i] = 0;
                mo[i] = -1; mgap[i] = 0;
            end else if (active[i]) begin
                m_push = vin[i] && ((mt[i] - mh[i]) < DEPTH);
                m_pop  = (mo[i] < 0) && (mgap[i] == 0) && (mt[i] != mh[i]);
                if (mo[i] >= 0) begin
                    mo[i]++;
                    if (mo[i] == 17 * hp(i)) begin
                        mo[i]   = -1;
                        mgap[i] = gp(i) * hp(i);
                        etx[i]  = 1'b1;
                    end
                end else if (mgap[i] > 0) begin
                    mgap[i]--;
                end else if (m_pop) begin
                    mcur[i] = mbuf[i][mh[i] % 256];
                    mh[i]++;
                    mo[i] = 0;
                    sbuf[i][st[i] % 256] = mcur[i];
                    st[i]++;
                end
                if (m_push) begin
                    mbuf[i][mt[i] % 256] = din[i];
                    mt[i]++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    int   c_p, c_k;
    logic e_cs, e_sck, e_mosi, e_busy, e_rdy;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (active[i]) begin
                if (mo[i] >= 0) begin
                    c_p    = mo[i] / hp(i);
                    c_k    = (c_p / 2 > 7) ? 7 : c_p / 2;
                    e_cs   = 1'b0;
                    e_sck  = (c_p % 2 == 1) && (c_p <= 15);
                    e_mosi = mcur[i][7 - c_k];
                end else begin
                    e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0;
                end
                e_busy = (mo[i] >= 0) || (mgap[i] > 0) || (mt[i] != mh[i]);
                e_rdy  = !rst[i] && ((mt[i] - mh[i]) < DEPTH);
                chk($sformatf("u%0d cs_n", i),    csn[i],  e_cs);
                chk($sformatf("u%0d sck", i),     sck[i],  e_sck);
                chk($sformatf("u%0d mosi", i),    mosi[i], e_mosi);
                chk($sformatf("u%0d tx_done", i), txd[i],  etx[i]);
                chk($sformatf("u%0d busy", i),    busy[i], e_busy);
                chk($sformatf("u%0d in_ready", i), rdy[i], e_rdy);
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver model: shift on sck rise, latch on cs_n rise
    // ------------------------------------------------------------------
    logic [1:0] pcs  = 2'b11;
    logic [1:0] psck = 2'b00;
    logic [7:0] rxsh [2];
    int rises [2]    = '{0, 0};
    int lowlen [2]   = '{0, 0};
    int hilen [2]    = '{0, 0};
    int last_low [2] = '{0, 0};
    int keys [2][64];
    int nkeys [2]    = '{0, 0};
    int gaps [2][64];
    int ngap [2]     = '{0, 0};
    int ntx [2]      = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i] || !active[i]) begin
                pcs[i] = 1'b1; psck[i] = 1'b0; rises[i] = 0;
                lowlen[i] = 0; hilen[i] = 0; rxsh[i] = 8'h00;
            end else begin
                if (!csn[i]) begin
                    lowlen[i]++;
                    if (pcs[i]) begin
                        if (ngap[i] < 64) gaps[i][ngap[i]] = hilen[i];
                        ngap[i]++;
                        hilen[i] = 0;
                    end
                    if (sck[i] && !psck[i]) begin
                        rxsh[i] = {rxsh[i][6:0], mosi[i]};
                        rises[i]++;
                    end
                end else begin
                    if (!pcs[i]) begin
                        last_low[i] = lowlen[i];
                        lowlen[i]   = 0;
                        chk($sformatf("u%0d rx key", i), rxsh[i], sbuf[i][sh[i] % 256]);
                        chk($sformatf("u%0d rx rises", i), rises[i], 8);
                        chk($sformatf("u%0d low len", i), last_low[i], 17 * hp(i));
                        sh[i]++;
                        if (nkeys[i] < 64) keys[i][nkeys[i]] = rxsh[i];
                        nkeys[i]++;
                        rises[i] = 0;
                    end
                    hilen[i]++;
                end
                if (txd[i]) ntx[i]++;
                pcs[i]  = csn[i];
                psck[i] = sck[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int stalls = 0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(int i, logic [7:0] d);
        int n;
        n = 0;
        vin[i] = 1'b1;
        din[i] = d;
        while (!rdy[i] && n < 500) begin
            stalls++;
            tick();
            n++;
        end
        if (n >= 500) chk("push timeout", 0, 1);
        tick();
        vin[i] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((busy[i] || !csn[i]) && n < 5000);
        if (n >= 5000) chk($sformatf("u%0d idle timeout", i), 0, 1);
    endtask

    logic [7:0] b2b [4]  = '{8'h01, 8'h80, 8'hFF, 8'h00};
    logic [7:0] five [5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    int nk, t0, n;

    initial begin
        rst = 2'b11;
        vin = 2'b00;
        din[0] = 8'h00;
        din[1] = 8'h00;
        repeat (3) tick();
        chk("ready during reset", rdy[0], 0);
        chk("cs_n in reset", csn[0], 1);
        rst[0] = 1'b0;
        #1;
        chk("ready after reset", rdy[0], 1);
        chk("busy after reset", busy[0], 0);

        // Single byte 0xA5
        t0 = ntx[0]; nk = nkeys[0];
        push(0, 8'hA5);
        wait_idle(0);
        chk("a5 low len", last_low[0], 68);
        chk("a5 key", keys[0][nk], 8'hA5);
        chk("a5 tx_done pulses", ntx[0] - t0, 1);

        // Back-to-back four bytes
        ngap[0] = 0; nk = nkeys[0]; stalls = 0;
        for (int j = 0; j < 4; j++) push(0, b2b[j]);
        chk("b2b stalls", stalls, 0);
        wait_idle(0);
        for (int j = 0; j < 4; j++) chk($sformatf("b2b key %0d", j), keys[0][nk + j], b2b[j]);
        chk("b2b gap count", ngap[0], 4);
        for (int j = 1; j < 4; j++) chk($sformatf("b2b gap %0d", j), gaps[0][j], 9);

        // Five bytes while a frame runs: FIFO fills, in_ready drops
        nk = nkeys[0];
        push(0, 8'h10);
        repeat (5) tick();
        stalls = 0;
        for (int j = 0; j < 5; j++) push(0, five[j]);
        chk("full stalled", (stalls > 0) ? 1 : 0, 1);
        wait_idle(0);
        chk("full frames", nkeys[0] - nk, 6);
        chk("full key first", keys[0][nk], 8'h10);
        for (int j = 0; j < 5; j++) chk($sformatf("full key %0d", j), keys[0][nk + 1 + j], five[j]);

        // Push and pop in the same cycle with three entries queued
        nk = nkeys[0];
        push(0, 8'h40);
        push(0, 8'h41);
        push(0, 8'h42);
        push(0, 8'h43);
        chk("pp count before", dut0.count, 3);
        n = 0;
        while (!txd[0] && n < 500) begin tick(); n++; end
        chk("pp saw tx_done", txd[0], 1);
        repeat (8) tick();
        chk("pp cs_n before pop", csn[0], 1);
        vin[0] = 1'b1; din[0] = 8'h44;
        tick();
        vin[0] = 1'b0;
        chk("pp count after", dut0.count, 3);
        chk("pp ready after", rdy[0], 1);
        tick();
        chk("pp cs_n falls", csn[0], 0);
        wait_idle(0);
        for (int j = 0; j < 5; j++) chk($sformatf("pp key %0d", j), keys[0][nk + j], 8'h40 + j);

        // Reset after the third sck rise
        t0 = ntx[0];
        push(0, 8'h3C);
        push(0, 8'h11);
        n = 0;
        while (rises[0] < 3 && n < 500) begin tick(); n++; end
        chk("rst saw 3 rises", rises[0], 3);
        rst[0] = 1'b1;
        tick();
        chk("rst cs_n", csn[0], 1);
        chk("rst sck", sck[0], 0);
        chk("rst mosi", mosi[0], 0);
        chk("rst busy", busy[0], 0);
        chk("rst tx_done", txd[0], 0);
        chk("rst fifo empty", dut0.count, 0);
        rst[0] = 1'b0;
        repeat (20) tick();
        chk("post rst idle cs_n", csn[0], 1);
        chk("post rst no tx_done", ntx[0] - t0, 0);

        // HALF=1, GAP=1 instance
        rst[1] = 1'b0;
        tick();
        nk = nkeys[1];
        push(1, 8'h5A);
        push(1, 8'hC3);
        wait_idle(1);
        chk("fast low len", last_low[1], 17);
        chk("fast key 0", keys[1][nk], 8'h5A);
        chk("fast key 1", keys[1][nk + 1], 8'hC3);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
